// File: rtl/stk_mc_if.sv
// stk_mc_if: command/response bus between the slave front-end and the multi-context stack engine
interface stk_mc_if #(
    parameter int W   = 64,
    parameter int CTX = 4
);
    localparam int CW = CTX > 1 ? $clog2(CTX) : 1;
    logic          i_cmd_vld;
    logic [CW-1:0] i_cmd_ctx;
    logic [1:0]    i_cmd_opcode;
    logic [W-1:0]  i_cmd_dat;
    logic          o_cmd_ack;
    logic          o_rsp_vld;
    logic          i_rsp_rdy;
    logic          o_rsp_err;
    logic [CW-1:0] o_rsp_ctx;
    logic [W-1:0]  o_rsp_dat;
    logic [CTX-1:0] o_full;
    logic [CTX-1:0] o_empty;
    modport slave (
        input  i_cmd_vld, i_cmd_ctx, i_cmd_opcode, i_cmd_dat, i_rsp_rdy,
        output o_cmd_ack, o_rsp_vld, o_rsp_err, o_rsp_ctx, o_rsp_dat, o_full, o_empty
    );
    modport master (
        output i_cmd_vld, i_cmd_ctx, i_cmd_opcode, i_cmd_dat, i_rsp_rdy,
        input  o_cmd_ack, o_rsp_vld, o_rsp_err, o_rsp_ctx, o_rsp_dat, o_full, o_empty
    );
endinterface

// File: rtl/stk_mc.sv
// stk_mc: CTX independent LIFO/FIFO stores in one shared array, one registered response per command
module stk_mc #(
    parameter int W     = 64,
    parameter int DEPTH = 16,
    parameter int CTX   = 4,
    parameter int MODE  = 0
) (
    input  logic     clk,
    input  logic     arst_n,
    stk_mc_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = CTX > 1 ? $clog2(CTX) : 1;
    localparam logic [AW:0] full_cnt = (AW+1)'(DEPTH);
    localparam logic [1:0] op_push = 2'd0, op_pop = 2'd1, op_peek = 2'd2, op_clear = 2'd3;

    logic [W-1:0]  mem [2**(CW+AW)];
    logic [AW:0]   cnt [CTX];
    logic [AW-1:0] rd_ptr [CTX];
    logic [AW-1:0] wr_ptr [CTX];
    logic [CW-1:0] c;
    logic [AW:0]   cur;
    logic [AW-1:0] widx, ridx;
    logic [W-1:0]  rdat;
    logic          acc, is_rd, c_full, c_empty, err;

    // single response slot: accept only when it is free or being drained this cycle
    assign bus.o_cmd_ack = arst_n & (~bus.o_rsp_vld | bus.i_rsp_rdy);
    assign acc = bus.i_cmd_vld & bus.o_cmd_ack;

    always_comb begin
        c       = bus.i_cmd_ctx;
        cur     = cnt[c];
        c_full  = cur == full_cnt;
        c_empty = cur == '0;
        is_rd   = bus.i_cmd_opcode == op_pop || bus.i_cmd_opcode == op_peek;
        err     = (bus.i_cmd_opcode == op_push && c_full) || (is_rd && c_empty);
        widx    = MODE != 0 ? wr_ptr[c] : cur[AW-1:0];
        ridx    = MODE != 0 ? rd_ptr[c] : cur[AW-1:0] - 1'b1;
        rdat    = is_rd && !c_empty ? mem[{c, ridx}] : '0;
    end

    always_ff @(posedge clk)
        if (acc && bus.i_cmd_opcode == op_push && !c_full)
            mem[{c, widx}] <= bus.i_cmd_dat;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            bus.o_rsp_vld <= 1'b0;
            bus.o_rsp_err <= 1'b0;
            bus.o_rsp_ctx <= '0;
            bus.o_rsp_dat <= '0;
            for (int i = 0; i < CTX; i++) begin
                cnt[i]    <= '0;
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
            end
        end else if (acc) begin
            bus.o_rsp_vld <= 1'b1;
            bus.o_rsp_err <= err;
            bus.o_rsp_ctx <= c;
            bus.o_rsp_dat <= rdat;
            if (!err)
                case (bus.i_cmd_opcode)
                    op_push: begin
                        cnt[c]    <= cur + 1'b1;
                        wr_ptr[c] <= wr_ptr[c] + 1'b1;
                    end
                    op_pop: begin
                        cnt[c]    <= cur - 1'b1;
                        rd_ptr[c] <= rd_ptr[c] + 1'b1;
                    end
                    op_clear: begin
                        cnt[c]    <= '0;
                        rd_ptr[c] <= '0;
                        wr_ptr[c] <= '0;
                    end
                    default: ;
                endcase
        end else if (bus.i_rsp_rdy) begin
            bus.o_rsp_vld <= 1'b0;
        end
    end

    for (genvar g = 0; g < CTX; g++) begin : g_flag
        assign bus.o_full[g]  = cnt[g] == full_cnt;
        assign bus.o_empty[g] = cnt[g] == '0;
    end
endmodule

// File: tb/tb_stk_mc.sv
// tb_stk_mc: drives a LIFO and a FIFO instance with identical commands, checks both against queue models
module tb_stk_mc;
    logic        clk = 1'b0;
    logic        arst_n, vld, rdy;
    logic [1:0]  opc, cctx;
    logic [63:0] dat;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    stk_mc_if #(.W(64), .CTX(4)) li ();
    stk_mc_if #(.W(64), .CTX(4)) fi ();

    stk_mc #(.W(64), .DEPTH(16), .CTX(4), .MODE(0)) u_lifo (.clk(clk), .arst_n(arst_n), .bus(li));
    stk_mc #(.W(64), .DEPTH(16), .CTX(4), .MODE(1)) u_fifo (.clk(clk), .arst_n(arst_n), .bus(fi));

    assign li.i_cmd_vld = vld;  assign fi.i_cmd_vld = vld;
    assign li.i_cmd_ctx = cctx; assign fi.i_cmd_ctx = cctx;
    assign li.i_cmd_opcode = opc; assign fi.i_cmd_opcode = opc;
    assign li.i_cmd_dat = dat;  assign fi.i_cmd_dat = dat;
    assign li.i_rsp_rdy = rdy;  assign fi.i_rsp_rdy = rdy;

    logic        ack [2], r_vld [2], r_err [2];
    logic [1:0]  r_ctx [2];
    logic [63:0] r_dat [2];
    logic [3:0]  full [2], empty [2];
    assign ack[0] = li.o_cmd_ack;   assign ack[1] = fi.o_cmd_ack;
    assign r_vld[0] = li.o_rsp_vld; assign r_vld[1] = fi.o_rsp_vld;
    assign r_err[0] = li.o_rsp_err; assign r_err[1] = fi.o_rsp_err;
    assign r_ctx[0] = li.o_rsp_ctx; assign r_ctx[1] = fi.o_rsp_ctx;
    assign r_dat[0] = li.o_rsp_dat; assign r_dat[1] = fi.o_rsp_dat;
    assign full[0] = li.o_full;     assign full[1] = fi.o_full;
    assign empty[0] = li.o_empty;   assign empty[1] = fi.o_empty;

    // reference: one queue per (instance, context); index 0 behaves as a stack, 1 as a queue
    logic [63:0] m [2][4][$];
    logic        exp_e [2];
    logic [63:0] exp_x [2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model(input int i, input logic [1:0] op, input logic [1:0] c, input logic [63:0] d,
                         output logic e, output logic [63:0] x);
        int n;
        n = m[i][c].size();
        e = 1'b0;
        x = '0;
        case (op)
            2'd0: if (n == 16) e = 1'b1; else m[i][c].push_back(d);
            2'd1, 2'd2: if (n == 0) e = 1'b1;
                else begin
                    x = i != 0 ? m[i][c][0] : m[i][c][n-1];
                    if (op == 2'd1) begin
                        if (i != 0) void'(m[i][c].pop_front());
                        else void'(m[i][c].pop_back());
                    end
                end
            default: m[i][c].delete();
        endcase
    endtask

    function automatic logic [3:0] exp_full(input int i);
        logic [3:0] r;
        for (int k = 0; k < 4; k++) r[k] = m[i][k].size() == 16;
        return r;
    endfunction

    function automatic logic [3:0] exp_empty(input int i);
        logic [3:0] r;
        for (int k = 0; k < 4; k++) r[k] = m[i][k].size() == 0;
        return r;
    endfunction

    task automatic send(input logic [1:0] op, input logic [1:0] c, input logic [63:0] d);
        logic e;
        logic [63:0] x;
        vld = 1'b1; opc = op; cctx = c; dat = d;
        #1;
        for (int i = 0; i < 2; i++) chk($sformatf("cmd_ack[%0d]", i), ack[i], 1);
        @(posedge clk);
        #1;
        vld = 1'b0;
        for (int i = 0; i < 2; i++) begin
            model(i, op, c, d, e, x);
            exp_e[i] = e;
            exp_x[i] = x;
            chk($sformatf("rsp_vld[%0d]", i), r_vld[i], 1);
            chk($sformatf("rsp_err[%0d]", i), r_err[i], e);
            chk($sformatf("rsp_ctx[%0d]", i), r_ctx[i], c);
            chk($sformatf("rsp_dat[%0d]", i), r_dat[i], x);
            chk($sformatf("full[%0d]", i), full[i], exp_full(i));
            chk($sformatf("empty[%0d]", i), empty[i], exp_empty(i));
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  c;
        logic [63:0] d;
        logic        le;
        logic [63:0] ld;
        logic        fe;
        logic [63:0] fd;
    } vec_t;
    vec_t tbl [17];

    initial begin
        tbl[0]  = '{2'd3, 2'd0, 64'h0,  1'b0, 64'h0,  1'b0, 64'h0};
        tbl[1]  = '{2'd0, 2'd1, 64'hA1, 1'b0, 64'h0,  1'b0, 64'h0};
        tbl[2]  = '{2'd0, 2'd1, 64'hB2, 1'b0, 64'h0,  1'b0, 64'h0};
        tbl[3]  = '{2'd0, 2'd1, 64'hC3, 1'b0, 64'h0,  1'b0, 64'h0};
        tbl[4]  = '{2'd1, 2'd1, 64'h0,  1'b0, 64'hC3, 1'b0, 64'hA1};
        tbl[5]  = '{2'd1, 2'd1, 64'h0,  1'b0, 64'hB2, 1'b0, 64'hB2};
        tbl[6]  = '{2'd1, 2'd1, 64'h0,  1'b0, 64'hA1, 1'b0, 64'hC3};
        tbl[7]  = '{2'd1, 2'd1, 64'h0,  1'b1, 64'h0,  1'b1, 64'h0};
        tbl[8]  = '{2'd0, 2'd1, 64'h5,  1'b0, 64'h0,  1'b0, 64'h0};
        tbl[9]  = '{2'd2, 2'd1, 64'h0,  1'b0, 64'h5,  1'b0, 64'h5};
        tbl[10] = '{2'd1, 2'd1, 64'h0,  1'b0, 64'h5,  1'b0, 64'h5};
        tbl[11] = '{2'd0, 2'd3, 64'h1,  1'b0, 64'h0,  1'b0, 64'h0};
        tbl[12] = '{2'd0, 2'd3, 64'h2,  1'b0, 64'h0,  1'b0, 64'h0};
        tbl[13] = '{2'd0, 2'd3, 64'h3,  1'b0, 64'h0,  1'b0, 64'h0};
        tbl[14] = '{2'd1, 2'd3, 64'h0,  1'b0, 64'h3,  1'b0, 64'h1};
        tbl[15] = '{2'd1, 2'd3, 64'h0,  1'b0, 64'h2,  1'b0, 64'h2};
        tbl[16] = '{2'd1, 2'd3, 64'h0,  1'b0, 64'h1,  1'b0, 64'h3};

        arst_n = 1'b0; vld = 1'b0; rdy = 1'b1; opc = '0; cctx = '0; dat = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("ack_in_reset", ack[0], 0);
        arst_n = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_ack[%0d]", i), ack[i], 1);
            chk($sformatf("rst_vld[%0d]", i), r_vld[i], 0);
            chk($sformatf("rst_err[%0d]", i), r_err[i], 0);
            chk($sformatf("rst_dat[%0d]", i), r_dat[i], 0);
            chk($sformatf("rst_ctx[%0d]", i), r_ctx[i], 0);
            chk($sformatf("rst_empty[%0d]", i), empty[i], 4'hF);
            chk($sformatf("rst_full[%0d]", i), full[i], 4'h0);
        end

        for (int k = 0; k < 17; k++) begin
            send(tbl[k].op, tbl[k].c, tbl[k].d);
            chk($sformatf("tbl%0d_lifo_err", k), r_err[0], tbl[k].le);
            chk($sformatf("tbl%0d_lifo_dat", k), r_dat[0], tbl[k].ld);
            chk($sformatf("tbl%0d_fifo_err", k), r_err[1], tbl[k].fe);
            chk($sformatf("tbl%0d_fifo_dat", k), r_dat[1], tbl[k].fd);
        end

        // fill ctx0 to the brim, then overflow
        for (int k = 0; k < 16; k++) send(2'd0, 2'd0, 64'h100 + 64'(k));
        chk("full0_lifo", full[0][0], 1);
        chk("full0_fifo", full[1][0], 1);
        send(2'd0, 2'd0, 64'hDEAD);
        chk("overflow_err", r_err[0], 1);
        send(2'd2, 2'd0, 64'h0);
        chk("top_after_overflow", r_dat[0], 64'h10F);
        chk("head_after_overflow", r_dat[1], 64'h100);
        send(2'd0, 2'd2, 64'h22);
        chk("push_ctx2_err", r_err[0], 0);
        chk("empty2_cleared", empty[0][2], 0);

        // backpressure: response held while a new command waits
        send(2'd0, 2'd2, 64'h77);
        rdy = 1'b0;
        vld = 1'b1; opc = 2'd2; cctx = 2'd2; dat = '0;
        repeat (3) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("stall_ack[%0d]", i), ack[i], 0);
                chk($sformatf("stall_vld[%0d]", i), r_vld[i], 1);
                chk($sformatf("stall_ctx[%0d]", i), r_ctx[i], 2);
                chk($sformatf("stall_dat[%0d]", i), r_dat[i], 0);
                chk($sformatf("stall_err[%0d]", i), r_err[i], 0);
            end
        end
        rdy = 1'b1;
        send(2'd2, 2'd2, 64'h0);
        chk("peek_after_stall_lifo", r_dat[0], 64'h77);
        chk("peek_after_stall_fifo", r_dat[1], 64'h22);

        // interleaved traffic on ctx3 walks the queue pointers round twice
        for (int k = 0; k < 40; k++) begin
            send(2'd0, 2'd3, {32'($urandom), 32'($urandom)});
            send(2'd1, 2'd3, 64'h0);
            chk("wrap_fifo_err", r_err[1], 0);
        end

        for (int k = 0; k < 5; k++) send(2'd0, 2'd3, 64'h300 + 64'(k));
        send(2'd3, 2'd3, 64'h0);
        chk("clear3_empty_lifo", empty[0][3], 1);
        chk("clear3_empty_fifo", empty[1][3], 1);
        send(2'd1, 2'd3, 64'h0);
        chk("pop_after_clear", r_err[0], 1);

        for (int k = 0; k < 400; k++) begin
            int r;
            r = $urandom_range(0, 9);
            send(r < 4 ? 2'd0 : r < 7 ? 2'd1 : r < 9 ? 2'd2 : 2'd3, 2'($urandom_range(0, 3)),
                 {32'($urandom), 32'($urandom)});
            if ($urandom_range(0, 3) == 0) begin
                rdy = 1'b0;
                @(posedge clk);
                #1;
                for (int i = 0; i < 2; i++) begin
                    chk($sformatf("rnd_hold_vld[%0d]", i), r_vld[i], 1);
                    chk($sformatf("rnd_hold_dat[%0d]", i), r_dat[i], exp_x[i]);
                    chk($sformatf("rnd_hold_err[%0d]", i), r_err[i], exp_e[i]);
                end
                rdy = 1'b1;
            end
        end

        // reset while a response is pending
        send(2'd0, 2'd1, 64'h99);
        rdy = 1'b0;
        arst_n = 1'b0;
        #1;
        chk("ack_low_in_reset", ack[1], 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("midrst_vld[%0d]", i), r_vld[i], 0);
            chk($sformatf("midrst_empty[%0d]", i), empty[i], 4'hF);
            chk($sformatf("midrst_full[%0d]", i), full[i], 4'h0);
            for (int k = 0; k < 4; k++) m[i][k].delete();
        end
        arst_n = 1'b1;
        rdy = 1'b1;
        send(2'd1, 2'd1, 64'h0);
        chk("pop_after_reset", r_err[0], 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
